krnl_cam_stream_ctrl: RTL and testbench

Parametrised command front-end for the CAM kernel. It sits between the host input stream (p0) and the CAM core, and between the CAM core result port and the host output stream (p1).
- Parses header beats carrying an opcode and a payload beat count, then steers exactly that many payload beats to the core with first/last markers.
- Buffers core results in an internal FWFT FIFO of configurable depth, with exact credit-based backpressure.
- Discards malformed commands and counts them.

---
 rtl/krnl_cam_stream_ctrl.sv | 107 ++++++++++
 tb/tb_krnl_cam_stream_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/krnl_cam_stream_ctrl.sv
// krnl_cam_stream_ctrl: parses host command headers, steers payload beats to the CAM core,
// and returns core results through a credit-guarded FWFT FIFO.
module krnl_cam_stream_ctrl #(
  parameter int C_DATA_WIDTH = 512,
  parameter int FIFO_DEPTH   = 32,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [C_DATA_WIDTH-1:0] p0_TDATA,
  input  logic                    p0_TVALID,
  output logic                    p0_TREADY,
  output logic [C_DATA_WIDTH-1:0] p1_TDATA,
  output logic                    p1_TVALID,
  output logic                    p1_TLAST,
  input  logic                    p1_TREADY,
  output logic [1:0]              cam_op,
  output logic [C_DATA_WIDTH-1:0] cam_tdata,
  output logic                    cam_tvalid,
  output logic                    cam_first,
  output logic                    cam_last,
  input  logic [C_DATA_WIDTH-1:0] res_tdata,
  input  logic                    res_tvalid,
  input  logic                    res_tlast,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    cmd_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d, cmd_q, cmd_d, err_q, err_d;
  logic [CNT_WIDTH:0] esum;
  logic [1:0] op_q, op_d, cop_q, cop_d;
  logic first_q, first_d, rdy_q, rdy_d;
  logic cv_q, cv_d, cf_q, cf_d, cl_q, cl_d;
  logic [C_DATA_WIDTH-1:0] cd_q, cd_d;
  logic [AW:0] out_q, out_d, cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [C_DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic acc, hdr_acc, beat, srch, res_ok, res_err, push, pop, op_ok, last;
  logic [31:0] hop, hn;
  assign acc = p0_TVALID & rdy_q;
  assign hop = p0_TDATA[31:0];
  assign hn = p0_TDATA[C_DATA_WIDTH-33 -: 32];
  assign op_ok = hop[31:2] == 30'h3fffffc0;
  assign last = rem_q == CNT_WIDTH'(1);
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) state_q <= S_HDR;
    else state_q <= state_d;
  // IDLE or zero-length commands complete in the header cycle itself
  always_comb begin
    state_d = state_q;
    if (acc) state_d = state_q == S_HDR ? ((hn == '0 || (op_ok && hop[1:0] == 2'b00)) ? S_HDR : op_ok ? S_PAY : S_DROP)
                                        : (last ? S_HDR : state_q);
  end
  always_comb begin
    hdr_acc = acc && state_q == S_HDR;
    beat    = acc && state_q == S_PAY;
    srch    = beat && op_q == 2'b11;
    res_ok  = res_tvalid && out_q != '0;
    res_err = res_tvalid && out_q == '0;
    push    = res_ok;
    pop     = cnt_q != '0 && p1_TREADY;
    rem_d   = hdr_acc ? CNT_WIDTH'(hn) : acc ? rem_q - CNT_WIDTH'(1) : rem_q;
    op_d    = hdr_acc ? hop[1:0] : op_q;
    first_d = hdr_acc ? 1'b1 : beat ? 1'b0 : first_q;
    cmd_d   = cmd_q + CNT_WIDTH'(hdr_acc && op_ok);
    esum    = {1'b0, err_q} + (CNT_WIDTH+1)'(hdr_acc && !op_ok) + (CNT_WIDTH+1)'(res_err);
    err_d   = esum[CNT_WIDTH] ? '1 : esum[CNT_WIDTH-1:0];
    out_d   = out_q + (AW+1)'(srch) - (AW+1)'(res_ok);
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wp_d    = wp_q + AW'(push);
    rp_d    = rp_q + AW'(pop);
    // ready lags free by one cycle; requiring two free slots absorbs the in-flight beat
    rdy_d   = (AW+2)'(cnt_q) + (AW+2)'(out_q) <= (AW+2)'(FIFO_DEPTH - 2);
    cv_d    = beat;
    cf_d    = beat && first_q;
    cl_d    = beat && last;
    cd_d    = beat ? p0_TDATA : cd_q;
    cop_d   = beat ? op_q : cop_q;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      rem_q <= '0; op_q <= '0; first_q <= 1'b0; cmd_q <= '0; err_q <= '0;
      out_q <= '0; cnt_q <= '0; wp_q <= '0; rp_q <= '0; rdy_q <= 1'b0;
      cv_q <= 1'b0; cf_q <= 1'b0; cl_q <= 1'b0; cd_q <= '0; cop_q <= '0;
    end else begin
      rem_q <= rem_d; op_q <= op_d; first_q <= first_d; cmd_q <= cmd_d; err_q <= err_d;
      out_q <= out_d; cnt_q <= cnt_d; wp_q <= wp_d; rp_q <= rp_d; rdy_q <= rdy_d;
      cv_q <= cv_d; cf_q <= cf_d; cl_q <= cl_d; cd_q <= cd_d; cop_q <= cop_d;
    end
  always_ff @(posedge ap_clk)
    if (push) mem[wp_q] <= {res_tlast, res_tdata};
  assign p0_TREADY  = rdy_q;
  assign p1_TVALID  = cnt_q != '0;
  assign p1_TDATA   = p1_TVALID ? mem[rp_q][C_DATA_WIDTH-1:0] : '0;
  assign p1_TLAST   = p1_TVALID & mem[rp_q][C_DATA_WIDTH];
  assign cam_op     = cop_q;
  assign cam_tdata  = cd_q;
  assign cam_tvalid = cv_q;
  assign cam_first  = cf_q;
  assign cam_last   = cl_q;
  assign busy       = state_q != S_HDR || cnt_q != '0 || out_q != '0;
  assign cmd_cnt    = cmd_q;
  assign err_cnt    = err_q;
endmodule

// File: tb/tb_krnl_cam_stream_ctrl.sv
// tb_krnl_cam_stream_ctrl: directed checks of command parsing, payload steering and result FIFO credit.
module tb_krnl_cam_stream_ctrl;
  localparam int W = 128, D = 4, CW = 32;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic [W-1:0] p0_TDATA = '0, p1_TDATA, cam_tdata, res_tdata;
  logic p0_TVALID = 1'b0, p0_TREADY, p1_TVALID, p1_TLAST, p1_TREADY = 1'b1;
  logic [1:0] cam_op;
  logic cam_tvalid, cam_first, cam_last, res_tvalid, res_tlast, busy;
  logic [CW-1:0] cmd_cnt, err_cnt;
  int n_chk = 0, n_fail = 0, cyc = 0;
  always #5 ap_clk = ~ap_clk;
  krnl_cam_stream_ctrl #(.C_DATA_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .p0_TDATA(p0_TDATA), .p0_TVALID(p0_TVALID),
    .p0_TREADY(p0_TREADY), .p1_TDATA(p1_TDATA), .p1_TVALID(p1_TVALID), .p1_TLAST(p1_TLAST),
    .p1_TREADY(p1_TREADY), .cam_op(cam_op), .cam_tdata(cam_tdata), .cam_tvalid(cam_tvalid),
    .cam_first(cam_first), .cam_last(cam_last), .res_tdata(res_tdata), .res_tvalid(res_tvalid),
    .res_tlast(res_tlast), .busy(busy), .cmd_cnt(cmd_cnt), .err_cnt(err_cnt));
  // core model: SEARCH beats echo back 3 cycles later as data+1
  logic [2:0] pv, pl;
  logic [W-1:0] pd [3];
  logic inj = 1'b0;
  always @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      pv <= '0;
      pl <= '0;
    end else begin
      pv <= {pv[1:0], cam_tvalid && cam_op == 2'b11};
      pl <= {pl[1:0], cam_last};
      pd[0] <= cam_tdata + W'(1);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
  assign res_tvalid = pv[2] | inj;
  assign res_tdata  = pd[2];
  assign res_tlast  = pv[2] & pl[2];
  logic [W-1:0] cam_d[$], p1_d[$];
  logic [1:0] cam_o[$];
  logic cam_f[$], cam_l[$], p1_l[$];
  int cam_c[$];
  always @(negedge ap_clk) begin
    cyc++;
    if (cam_tvalid) begin
      cam_d.push_back(cam_tdata); cam_o.push_back(cam_op);
      cam_f.push_back(cam_first); cam_l.push_back(cam_last); cam_c.push_back(cyc);
    end
    if (p1_TVALID && p1_TREADY) begin
      p1_d.push_back(p1_TDATA); p1_l.push_back(p1_TLAST);
    end
  end
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] hdr(input logic [31:0] op, input logic [31:0] n);
    return {32'h0, n, 32'h0, op};
  endfunction
  task automatic send(input logic [W-1:0] d);
    int k = 0;
    p0_TDATA = d;
    p0_TVALID = 1'b1;
    while (1) begin
      @(negedge ap_clk);
      if (p0_TREADY || k > 300) break;
      k++;
    end
    if (k > 300) chk("p0_accept_timeout", W'(p0_TREADY), W'(1));
    else @(posedge ap_clk);
    #1 p0_TVALID = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask
  task automatic clr();
    cam_d.delete(); cam_o.delete(); cam_f.delete(); cam_l.delete(); cam_c.delete();
    p1_d.delete(); p1_l.delete();
  endtask
  task automatic reset_outputs(input string t);
    chk({t, "_tready"}, W'(p0_TREADY), '0);
    chk({t, "_p1v"}, W'(p1_TVALID), '0);
    chk({t, "_p1d"}, p1_TDATA, '0);
    chk({t, "_camv"}, W'(cam_tvalid), '0);
    chk({t, "_camd"}, cam_tdata, '0);
    chk({t, "_op"}, W'(cam_op), '0);
    chk({t, "_busy"}, W'(busy), '0);
    chk({t, "_cmd"}, W'(cmd_cnt), '0);
    chk({t, "_err"}, W'(err_cnt), '0);
  endtask
  initial begin
    #12 reset_outputs("rst");
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); @(posedge ap_clk); #1;
    chk("rdy_after_rst", W'(p0_TREADY), W'(1));
    // SEARCH N=4
    clr();
    send(hdr(32'hffffff03, 4));
    for (int i = 0; i < 4; i++) send(W'(32'ha0 + i));
    idle(20);
    chk("s4_cam_n", W'(cam_d.size()), W'(4));
    for (int i = 0; i < 4; i++) begin
      chk("s4_op", W'(cam_o[i]), W'(2'b11));
      chk("s4_first", W'(cam_f[i]), W'(i == 0));
      chk("s4_last", W'(cam_l[i]), W'(i == 3));
      chk("s4_data", cam_d[i], W'(32'ha0 + i));
    end
    chk("s4_consec", W'(cam_c[3] - cam_c[0]), W'(3));
    chk("s4_p1_n", W'(p1_d.size()), W'(4));
    for (int i = 0; i < 4; i++) begin
      chk("s4_res", p1_d[i], W'(32'ha1 + i));
      chk("s4_tlast", W'(p1_l[i]), W'(i == 3));
    end
    chk("s4_cmd", W'(cmd_cnt), W'(1));
    chk("s4_busy", W'(busy), '0);
    // UPDATE_ALL N=2 then UPDATE_ONE N=1
    clr();
    send(hdr(32'hffffff01, 2)); send(W'(32'h11)); send(W'(32'h12));
    send(hdr(32'hffffff02, 1)); send(W'(32'h13));
    idle(10);
    chk("upd_cam_n", W'(cam_d.size()), W'(3));
    for (int i = 0; i < 3; i++) begin
      chk("upd_op", W'(cam_o[i]), W'(i == 2 ? 2'b10 : 2'b01));
      chk("upd_first", W'(cam_f[i]), W'(i != 1));
      chk("upd_last", W'(cam_l[i]), W'(i != 0));
      chk("upd_data", cam_d[i], W'(32'h11 + i));
    end
    chk("upd_p1_n", W'(p1_d.size()), '0);
    chk("upd_busy", W'(busy), '0);
    chk("upd_cmd", W'(cmd_cnt), W'(3));
    // unknown opcode N=3 dropped, then SEARCH N=1
    clr();
    send(hdr(32'h12345678, 3));
    for (int i = 0; i < 3; i++) send(W'(32'h20 + i));
    send(hdr(32'hffffff03, 1)); send(W'(32'h30));
    idle(10);
    chk("drop_cam_n", W'(cam_d.size()), W'(1));
    chk("drop_cam_d", cam_d[0], W'(32'h30));
    chk("drop_cam_fl", W'({cam_f[0], cam_l[0]}), W'(2'b11));
    chk("drop_err", W'(err_cnt), W'(1));
    chk("drop_p1_n", W'(p1_d.size()), W'(1));
    chk("drop_res", p1_d[0], W'(32'h31));
    chk("drop_tlast", W'(p1_l[0]), W'(1));
    chk("drop_cmd", W'(cmd_cnt), W'(4));
    // credit backpressure with a stalled consumer
    clr();
    p1_TREADY = 1'b0;
    fork
      begin
        send(hdr(32'hffffff03, 10));
        for (int i = 0; i < 10; i++) send(W'(32'h100 + i));
      end
      begin
        idle(30);
        chk("bp_cam_n", W'(cam_d.size()), W'(4));
        chk("bp_tready", W'(p0_TREADY), '0);
        chk("bp_p1v", W'(p1_TVALID), W'(1));
        p1_TREADY = 1'b1;
      end
    join
    idle(20);
    chk("bp_cam_total", W'(cam_d.size()), W'(10));
    chk("bp_p1_n", W'(p1_d.size()), W'(10));
    for (int i = 0; i < 10; i++) begin
      chk("bp_res", p1_d[i], W'(32'h101 + i));
      chk("bp_tlast", W'(p1_l[i]), W'(i == 9));
    end
    chk("bp_busy", W'(busy), '0);
    // unexpected result, IDLE with nonzero N, SEARCH N=0
    clr();
    @(posedge ap_clk); #1 inj = 1'b1;
    @(posedge ap_clk); #1 inj = 1'b0;
    idle(3);
    chk("unexp_err", W'(err_cnt), W'(2));
    chk("unexp_p1v", W'(p1_TVALID), '0);
    chk("unexp_p1_n", W'(p1_d.size()), '0);
    send(hdr(32'hffffff00, 2));
    send(hdr(32'hffffff03, 0));
    idle(5);
    chk("corner_cam_n", W'(cam_d.size()), '0);
    chk("corner_cmd", W'(cmd_cnt), W'(7));
    chk("corner_busy", W'(busy), '0);
    // asynchronous reset mid-command
    send(hdr(32'hffffff03, 5)); send(W'(32'h200)); send(W'(32'h201));
    #3 ap_rst_n = 1'b0;
    #1 reset_outputs("arst");
    idle(3);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); @(posedge ap_clk); #1;
    clr();
    send(hdr(32'hffffff03, 1)); send(W'(32'h300));
    idle(10);
    chk("post_cam_n", W'(cam_d.size()), W'(1));
    chk("post_cam_d", cam_d[0], W'(32'h300));
    chk("post_cam_fl", W'({cam_f[0], cam_l[0]}), W'(2'b11));
    chk("post_p1_n", W'(p1_d.size()), W'(1));
    chk("post_res", p1_d[0], W'(32'h301));
    chk("post_cmd", W'(cmd_cnt), W'(1));
    chk("post_err", W'(err_cnt), '0);
    chk("post_busy", W'(busy), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
